// File: rtl/multdiv_pkg.sv
// rtl/multdiv_pkg.sv - shared types and sizing constants for the iterative multiply/divide unit
package multdiv_pkg;

    localparam int DEFAULT_WIDTH = 32;
    localparam int CNT_W         = $clog2(DEFAULT_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OP_MUL = 1'b0,
        OP_DIV = 1'b1
    } op_t;

endpackage

// File: rtl/multdiv_if.sv
// rtl/multdiv_if.sv - X-stage request/response bundle between pipeline and multdiv unit
interface multdiv_if #(parameter int WIDTH = multdiv_pkg::DEFAULT_WIDTH);

    logic             ctrl_MULT;
    logic             ctrl_DIV;
    logic             flush;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
    logic             busy;

    modport slave (
        input  ctrl_MULT, ctrl_DIV, flush, data_operandA, data_operandB,
        output data_result, data_exception, data_resultRDY, busy
    );

    modport master (
        output ctrl_MULT, ctrl_DIV, flush, data_operandA, data_operandB,
        input  data_result, data_exception, data_resultRDY, busy
    );

endinterface

// File: rtl/multdiv_unit_sign_mag_conv.sv
// rtl/multdiv_unit_sign_mag_conv.sv - conditional two's-complement negate (abs or signed result)
module sign_mag_conv #(
    parameter int W = 32
) (
    input  logic [W-1:0] i_val,
    input  logic         i_neg,
    output logic [W-1:0] o_val
);

    assign o_val = i_neg ? (~i_val + W'(1)) : i_val;

endmodule

// File: rtl/multdiv_unit.sv
// rtl/multdiv_unit.sv - iterative signed shift-add multiply / restoring divide, one bit per clock
// Optional: define MULTDIV_EARLY_TERM_EN to end a multiply once the remaining multiplier bits are zero.
module multdiv_unit
    import multdiv_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic       clock,
    input  logic       reset,
    multdiv_if.slave   bus
);

    localparam int CW = (WIDTH == DEFAULT_WIDTH) ? CNT_W : $clog2(WIDTH);

    state_t             r_state, w_state_nx;
    op_t                r_op;
    logic               r_sign, r_dz, r_exc;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_b, r_result;
    logic [2*WIDTH-1:0] r_mc, r_acc;

    logic [WIDTH-1:0]   w_abs_a, w_abs_b, w_b_shr, w_fin_res;
    logic [WIDTH:0]     w_rsh, w_diff;
    logic [2*WIDTH-1:0] w_mul_acc, w_div_acc, w_acc_nx, w_mag, w_signed;
    logic               w_start, w_q_bit, w_last, w_mul_ovf, w_div_ovf, w_fin_exc;

    sign_mag_conv #(.W(WIDTH)) u_conv_a (
        .i_val(bus.data_operandA), .i_neg(bus.data_operandA[WIDTH-1]), .o_val(w_abs_a)
    );
    sign_mag_conv #(.W(WIDTH)) u_conv_b (
        .i_val(bus.data_operandB), .i_neg(bus.data_operandB[WIDTH-1]), .o_val(w_abs_b)
    );

    assign w_start = (r_state == IDLE) && (bus.ctrl_MULT || bus.ctrl_DIV) && !bus.flush;

    // Multiply: multiplicand shifts left, multiplier shifts right, so early exit leaves an exact product.
    assign w_mul_acc = r_acc + (r_b[0] ? r_mc : '0);
    assign w_b_shr   = r_b >> 1;

    // Divide: r_acc holds {remainder, dividend/quotient}; quotient bits enter at the LSB.
    assign w_rsh     = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
    assign w_diff    = w_rsh - {1'b0, r_b};
    assign w_q_bit   = ~w_diff[WIDTH];
    assign w_div_acc = {(w_q_bit ? w_diff[WIDTH-1:0] : w_rsh[WIDTH-1:0]), r_acc[WIDTH-2:0], w_q_bit};

    assign w_acc_nx  = (r_op == OP_MUL) ? w_mul_acc : w_div_acc;

`ifdef MULTDIV_EARLY_TERM_EN
    assign w_last = (r_cnt == CW'(WIDTH-1)) || ((r_op == OP_MUL) && (w_b_shr == '0));
`else
    assign w_last = (r_cnt == CW'(WIDTH-1));
`endif

    assign w_mag = (r_op == OP_MUL) ? w_acc_nx : {{WIDTH{1'b0}}, w_acc_nx[WIDTH-1:0]};

    sign_mag_conv #(.W(2*WIDTH)) u_conv_res (
        .i_val(w_mag), .i_neg(r_sign), .o_val(w_signed)
    );

    assign w_mul_ovf = !((&w_signed[2*WIDTH-1:WIDTH-1]) || !(|w_signed[2*WIDTH-1:WIDTH-1]));
    // A quotient magnitude of 2^(WIDTH-1) only fits when the result is negative.
    assign w_div_ovf = w_acc_nx[WIDTH-1] && !r_sign;
    assign w_fin_res = ((r_op == OP_DIV) && r_dz) ? '0 : w_signed[WIDTH-1:0];
    assign w_fin_exc = (r_op == OP_MUL) ? w_mul_ovf : (r_dz || w_div_ovf);

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            IDLE:    if (w_start) w_state_nx = RUN;
            RUN:     if (bus.flush) w_state_nx = IDLE;
                     else if (w_last) w_state_nx = DONE;
            DONE:    w_state_nx = IDLE;
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= IDLE;
            r_op     <= OP_MUL;
            r_sign   <= 1'b0;
            r_dz     <= 1'b0;
            r_cnt    <= '0;
            r_b      <= '0;
            r_mc     <= '0;
            r_acc    <= '0;
            r_result <= '0;
            r_exc    <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            if (w_start) begin
                r_op   <= bus.ctrl_MULT ? OP_MUL : OP_DIV;
                r_sign <= bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
                r_dz   <= (bus.data_operandB == '0);
                r_cnt  <= '0;
                r_b    <= w_abs_b;
                r_mc   <= {{WIDTH{1'b0}}, w_abs_a};
                r_acc  <= bus.ctrl_MULT ? '0 : {{WIDTH{1'b0}}, w_abs_a};
            end else if ((r_state == RUN) && !bus.flush) begin
                r_cnt <= r_cnt + CW'(1);
                r_b   <= (r_op == OP_MUL) ? w_b_shr : r_b;
                r_mc  <= r_mc << 1;
                r_acc <= w_acc_nx;
                if (w_last) begin
                    r_result <= w_fin_res;
                    r_exc    <= w_fin_exc;
                end
            end
        end
    end

    assign bus.busy           = (r_state != IDLE);
    assign bus.data_resultRDY = (r_state == DONE) && !bus.flush;
    assign bus.data_result    = r_result;
    assign bus.data_exception = r_exc;

endmodule

// File: tb/tb_multdiv_unit.sv
// tb/tb_multdiv_unit.sv - directed self-checking bench for multdiv_unit
module tb_multdiv_unit;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    multdiv_if #(.WIDTH(32)) bus ();

    multdiv_unit #(.WIDTH(32)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int mlat(input int k);
`ifdef MULTDIV_EARLY_TERM_EN
        return k;
`else
        return 32;
`endif
    endfunction

    task automatic do_op(input string tag, input logic mul, input logic div,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp_r, input logic exp_e, input int exp_k);
        int   n;
        logic busy_ok;
        @(negedge clock);
        bus.ctrl_MULT = mul;
        bus.ctrl_DIV = div;
        bus.data_operandA = a;
        bus.data_operandB = b;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.data_operandA = 32'hDEADBEEF;
        bus.data_operandB = 32'h0BADF00D;
        n = 0;
        busy_ok = 1'b1;
        while (!bus.data_resultRDY && n < 40) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clock);
            n++;
            @(negedge clock);
        end
        check({tag, "_latency"}, 64'(n), 64'(exp_k));
        check({tag, "_result"}, 64'(bus.data_result), 64'(exp_r));
        check({tag, "_exception"}, 64'(bus.data_exception), 64'(exp_e));
        check({tag, "_busy_inflight"}, 64'(busy_ok), 64'(1));
        check({tag, "_busy_at_rdy"}, 64'(bus.busy), 64'(1));
        @(posedge clock);
        @(negedge clock);
        check({tag, "_rdy_one_cycle"}, 64'(bus.data_resultRDY), 64'(0));
        check({tag, "_busy_after"}, 64'(bus.busy), 64'(0));
        check({tag, "_result_held"}, 64'(bus.data_result), 64'(exp_r));
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic saw_rdy;
        bus.ctrl_MULT = 1'b0;
        bus.ctrl_DIV = 1'b0;
        bus.flush = 1'b0;
        bus.data_operandA = '0;
        bus.data_operandB = '0;
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("rst_result", 64'(bus.data_result), 64'(0));
        check("rst_exception", 64'(bus.data_exception), 64'(0));
        check("rst_rdy", 64'(bus.data_resultRDY), 64'(0));
        check("rst_busy", 64'(bus.busy), 64'(0));
        reset = 1'b1;

        do_op("mul_7_m6",    1, 0, 32'h00000007, 32'hFFFFFFFA, 32'hFFFFFFD6, 1'b0, mlat(3));
        do_op("mul_ovf",     1, 0, 32'h00010000, 32'h00010000, 32'h00000000, 1'b1, mlat(17));
        do_op("div_m7_2",    0, 1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 1'b0, 32);
        do_op("div_by_zero", 0, 1, 32'h00000005, 32'h00000000, 32'h00000000, 1'b1, 32);
        do_op("div_minneg",  0, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, 32);
        do_op("div_100_m7",  0, 1, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 1'b0, 32);
        do_op("mul_minneg1", 1, 0, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1'b1, mlat(1));
        do_op("mul_minneg_1",1, 0, 32'h80000000, 32'h00000001, 32'h80000000, 1'b0, mlat(1));
        do_op("mul_both",    1, 1, 32'h00000006, 32'h00000003, 32'h00000012, 1'b0, mlat(2));
        do_op("mul_by_zero", 1, 0, 32'h00000005, 32'h00000000, 32'h00000000, 1'b0, mlat(1));
        do_op("mul_123_3",   1, 0, 32'h0000007B, 32'h00000003, 32'h00000171, 1'b0, mlat(2));

        // start together with flush in IDLE must not launch an operation
        @(negedge clock);
        bus.ctrl_MULT = 1'b1;
        bus.flush = 1'b1;
        bus.data_operandA = 32'd2;
        bus.data_operandB = 32'd2;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        bus.flush = 1'b0;
        check("flush_start_busy", 64'(bus.busy), 64'(0));

        // multiply aborted by flush; a divide pulse mid-run is ignored
        @(negedge clock);
        bus.ctrl_MULT = 1'b1;
        bus.data_operandA = 32'h00000001;
        bus.data_operandB = 32'h40000000;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_MULT = 1'b0;
        saw_rdy = 1'b0;
        for (int e = 1; e <= 21; e++) begin
            @(posedge clock);
            @(negedge clock);
            saw_rdy = saw_rdy | bus.data_resultRDY;
            if (e == 9)  bus.ctrl_DIV = 1'b1;
            if (e == 10) bus.ctrl_DIV = 1'b0;
            if (e == 20) begin
                check("flush_busy_before", 64'(bus.busy), 64'(1));
                bus.flush = 1'b1;
            end
            if (e == 21) bus.flush = 1'b0;
        end
        check("flush_busy_low", 64'(bus.busy), 64'(0));
        for (int i = 0; i < 15; i++) begin
            @(posedge clock);
            @(negedge clock);
            saw_rdy = saw_rdy | bus.data_resultRDY | bus.busy;
        end
        check("flush_no_rdy", 64'(saw_rdy), 64'(0));
        check("flush_result_kept", 64'(bus.data_result), 64'(32'h00000171));
        check("flush_exc_kept", 64'(bus.data_exception), 64'(0));

        // asynchronous reset in the middle of a divide
        @(negedge clock);
        bus.ctrl_DIV = 1'b1;
        bus.data_operandA = 32'd100;
        bus.data_operandB = 32'd7;
        @(posedge clock);
        @(negedge clock);
        bus.ctrl_DIV = 1'b0;
        repeat (15) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("arst_result", 64'(bus.data_result), 64'(0));
        check("arst_exception", 64'(bus.data_exception), 64'(0));
        check("arst_rdy", 64'(bus.data_resultRDY), 64'(0));
        check("arst_busy", 64'(bus.busy), 64'(0));
        @(negedge clock);
        reset = 1'b1;
        do_op("mul_3_4", 1, 0, 32'h00000003, 32'h00000004, 32'h0000000C, 1'b0, mlat(3));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/multdiv_unit.md
Name: multdiv_unit

Overview:
- Iterative signed multiply/divide unit in the X stage, directly downstream of the operand bypass network.
- Consumes the forwarded X-stage A/B operands when the decoded instruction is mul/div.
- Returns a result plus an overflow/div-by-zero exception to the X/M latch.
- Drives busy so the stall logic freezes PC, F/D and D/X while an operation is in flight.

Parameters:
WIDTH, 32, operand/result width in bits; iteration count equals WIDTH.

Ports:
clock  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset; 0 clears all state
ctrl_MULT  input  1  start pulse, multiply; sampled only in IDLE
ctrl_DIV  input  1  start pulse, divide; sampled only in IDLE
flush  input  1  abort in-flight operation (branch/jump squash of X)
data_operandA  input  WIDTH  forwarded operand A (multiplicand/dividend)
data_operandB  input  WIDTH  forwarded operand B (multiplier/divisor)
data_result  output  WIDTH  product low bits or quotient; held until next accepted start
data_exception  output  1  overflow or divide-by-zero; held with data_result
data_resultRDY  output  1  one-cycle completion strobe
busy  output  1  high from the accepting edge through the RDY cycle, inclusive

Behaviour:
- Reset (async, reset=0): state=IDLE, counter=0, data_result=0, data_exception=0, data_resultRDY=0, busy=0.
- States:
  - IDLE: on ctrl_MULT or ctrl_DIV, go to RUN.
  - RUN: after the last iteration, go to DONE.
  - DONE: go to IDLE on the next edge.
- Start acceptance (IDLE only):
  - Operands are latched and converted to magnitudes; the result sign is stored as signA XOR signB; counter=0.
  - ctrl_MULT and ctrl_DIV both high: treated as multiply.
  - Start pulses in RUN or DONE are ignored.
- Multiply: radix-2 shift-add on magnitudes, 2*WIDTH-bit product, one multiplier bit per edge, LSB first.
- Divide: restoring division on magnitudes, one quotient bit per edge, MSB first. The remainder is internal only.
- Latency:
  - RUN performs iterations on edges E1..E32 after the accepting edge E0.
  - E32 enters DONE; data_resultRDY is high during the cycle after E32 only.
  - data_result and data_exception update at E32 and are stable while RDY is high.
- Result sign:
  - Apply conditional two's-complement negation using the stored sign.
  - Quotient truncates toward zero.
- Multiply exception: set when the signed 2*WIDTH-bit product does not fit in WIDTH bits (upper WIDTH+1 bits not all equal). data_result = low WIDTH bits.
- Divide-by-zero (B=0, detected at start): full latency, result=0, exception=1.
- Most-negative / -1 (0x80000000 / 0xFFFFFFFF): result=0x80000000, exception=1.
- flush:
  - In RUN or DONE: state goes to IDLE at the next edge and RDY is suppressed (low) in that cycle.
  - data_result and data_exception keep their prior values.
  - flush together with a start in IDLE: the start is ignored.
- busy is combinational from state: busy = (state != IDLE).

Optional Feature:
MULTDIV_EARLY_TERM_EN
- Defined (multiply only): after each iteration, if the remaining unshifted multiplier magnitude bits are all zero, go to DONE.
  - DONE is entered at edge Ek, k = max(1, msb_index(|B|)+1), so RDY falls in the cycle after Ek.
  - |B|=0 gives k=1.
  - Divide is unaffected.
- Undefined: fixed 32-iteration latency for all operations.

Decomposition:
- multdiv_pkg: state enum (IDLE, RUN, DONE), op enum (OP_MUL, OP_DIV), WIDTH default constant, counter-width constant ($clog2(WIDTH)).
- One sub-module: sign_mag_conv (abs of a signed value / conditional negate of a magnitude). Instantiated for A, B and the result.

Test Plan:
- 7 * -6 (0x00000007, 0xFFFFFFFA) -> result 0xFFFFFFD6, exception 0, RDY exactly in cycle after E32, busy high E0..RDY cycle.
- 0x00010000 * 0x00010000 -> result 0x00000000, exception 1; -7 / 2 -> 0xFFFFFFFD, exception 0.
- 5 / 0 -> result 0, exception 1 at full latency; 0x80000000 / 0xFFFFFFFF -> 0x80000000, exception 1.
- MULT start, ctrl_DIV pulse at E10, flush at E20 -> DIV ignored, no RDY, busy low after E21, data_result unchanged from previous op.
- reset driven low at E15 of a divide -> all outputs 0 immediately (async); next MULT 3*4 -> 12 with normal latency.
- With MULTDIV_EARLY_TERM_EN: 123 * 3 -> result 369, RDY in cycle after E2; 0 * x -> RDY after E1; divide latency still 32.
